vxe_mem_hub_cu_dstream: RTL and testbench

//  Client-unit downstream path of the VxE memory hub. Routes read responses from one of two

---
 rtl/vxe_mem_hub_cu_dstream_if.sv | 70 +++++++
 rtl/vxe_mem_hub_cu_dstream.sv | 95 +++++++++
 tb/tb_vxe_mem_hub_cu_dstream.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vxe_mem_hub_cu_dstream_if.sv
// Downstream response bus between the client-unit hub and its FIFO neighbours.
// Master modport is the hub side; slave modport is the surrounding FIFOs.
interface vxe_mem_hub_cu_dstream_if #(
  parameter int RSS_W = 9,
  parameter int RSD_W = 64
);
  logic             i_m_sel;
  logic             i_rss_rdy;
  logic [RSS_W-1:0] o_rss;
  logic             o_rss_wr;
  logic             i_rsd_rdy;
  logic [RSD_W-1:0] o_rsd;
  logic             o_rsd_wr;
  logic             i_m0_rss_vld;
  logic [RSS_W-1:0] i_m0_rss;
  logic             o_m0_rss_rd;
  logic             i_m0_rsd_vld;
  logic [RSD_W-1:0] i_m0_rsd;
  logic             o_m0_rsd_rd;
  logic             i_m1_rss_vld;
  logic [RSS_W-1:0] i_m1_rss;
  logic             o_m1_rss_rd;
  logic             i_m1_rsd_vld;
  logic [RSD_W-1:0] i_m1_rsd;
  logic             o_m1_rsd_rd;

  modport master (
    input  i_m_sel,
    input  i_rss_rdy,
    output o_rss,
    output o_rss_wr,
    input  i_rsd_rdy,
    output o_rsd,
    output o_rsd_wr,
    input  i_m0_rss_vld,
    input  i_m0_rss,
    output o_m0_rss_rd,
    input  i_m0_rsd_vld,
    input  i_m0_rsd,
    output o_m0_rsd_rd,
    input  i_m1_rss_vld,
    input  i_m1_rss,
    output o_m1_rss_rd,
    input  i_m1_rsd_vld,
    input  i_m1_rsd,
    output o_m1_rsd_rd
  );

  modport slave (
    output i_m_sel,
    output i_rss_rdy,
    input  o_rss,
    input  o_rss_wr,
    output i_rsd_rdy,
    input  o_rsd,
    input  o_rsd_wr,
    output i_m0_rss_vld,
    output i_m0_rss,
    input  o_m0_rss_rd,
    output i_m0_rsd_vld,
    output i_m0_rsd,
    input  o_m0_rsd_rd,
    output i_m1_rss_vld,
    output i_m1_rss,
    input  o_m1_rss_rd,
    output i_m1_rsd_vld,
    output i_m1_rsd,
    input  o_m1_rsd_rd
  );
endinterface

// File: rtl/vxe_mem_hub_cu_dstream.sv
// Hub client-unit downstream path: master response FIFOs -> client FIFOs.
// Define VXE_CU_DS_BYPASS_EN for zero-latency combinational channels.
module vxe_mem_hub_cu_dstream #(
  parameter int RSS_W = 9,
  parameter int RSD_W = 64
) (
  input logic                     clk,
  input logic                     rst,
  vxe_mem_hub_cu_dstream_if.master bus
);

  logic             sel;
  logic             rss_vld;
  logic [RSS_W-1:0] rss_head;
  logic             rsd_vld;
  logic [RSD_W-1:0] rsd_head;
  logic             rss_pop;
  logic             rsd_pop;

  assign sel = bus.i_m_sel;

  always_comb begin
    rss_vld  = bus.i_m0_rss_vld;
    rss_head = bus.i_m0_rss;
    rsd_vld  = bus.i_m0_rsd_vld;
    rsd_head = bus.i_m0_rsd;
    if (sel) begin
      rss_vld  = bus.i_m1_rss_vld;
      rss_head = bus.i_m1_rss;
      rsd_vld  = bus.i_m1_rsd_vld;
      rsd_head = bus.i_m1_rsd;
    end
  end

`ifdef VXE_CU_DS_BYPASS_EN

  assign rss_pop      = rss_vld & bus.i_rss_rdy & ~rst;
  assign rsd_pop      = rsd_vld & bus.i_rsd_rdy & ~rst;
  assign bus.o_rss    = rss_head;
  assign bus.o_rss_wr = rss_vld & ~rst;
  assign bus.o_rsd    = rsd_head;
  assign bus.o_rsd_wr = rsd_vld & ~rst;

`else

  logic             rss_q_vld;
  logic [RSS_W-1:0] rss_q;
  logic             rss_load;
  logic             rsd_q_vld;
  logic [RSD_W-1:0] rsd_q;
  logic             rsd_load;

  // Register accepts a new word when empty or draining this cycle.
  assign rss_load = ~rss_q_vld | bus.i_rss_rdy;
  assign rsd_load = ~rsd_q_vld | bus.i_rsd_rdy;
  assign rss_pop  = rss_vld & rss_load & ~rst;
  assign rsd_pop  = rsd_vld & rsd_load & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      rss_q_vld <= 1'b0;
      rss_q     <= '0;
    end else if (rss_pop) begin
      rss_q_vld <= 1'b1;
      rss_q     <= rss_head;
    end else if (bus.i_rss_rdy) begin
      rss_q_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsd_q_vld <= 1'b0;
      rsd_q     <= '0;
    end else if (rsd_pop) begin
      rsd_q_vld <= 1'b1;
      rsd_q     <= rsd_head;
    end else if (bus.i_rsd_rdy) begin
      rsd_q_vld <= 1'b0;
    end
  end

  assign bus.o_rss    = rss_q;
  assign bus.o_rss_wr = rss_q_vld;
  assign bus.o_rsd    = rsd_q;
  assign bus.o_rsd_wr = rsd_q_vld;

`endif

  assign bus.o_m0_rss_rd = rss_pop & ~sel;
  assign bus.o_m1_rss_rd = rss_pop & sel;
  assign bus.o_m0_rsd_rd = rsd_pop & ~sel;
  assign bus.o_m1_rsd_rd = rsd_pop & sel;

endmodule

// File: tb/tb_vxe_mem_hub_cu_dstream.sv
// Randomized scoreboard bench for the hub downstream path.
// Master FIFOs are modelled as bounded queues driven from the bench.
module tb_vxe_mem_hub_cu_dstream;

  logic clk;
  logic rst;

  vxe_mem_hub_cu_dstream_if bus ();

  vxe_mem_hub_cu_dstream dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef VXE_CU_DS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // [master][channel], channel 0 = status, 1 = data
  logic [63:0] mq [2][2][$];
  logic [63:0] eq [2][2][$];
  int          cnt [2][2];
  bit          pop_f [2][2];
  bit          gen_on;

  int tests;
  int fails;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mkword(input int m,
                                         input int c,
                                         input int n);
    logic [7:0] lo;
    lo = n[7:0];
    if (c == 0)
      return (m == 1) ? (64'h100 | 64'(lo)) : 64'(lo);
    return (m == 1) ? (64'hFE00_0000_0000_0000 | 64'(n))
                    : 64'(n);
  endfunction

  task automatic drive();
    logic [63:0] h [2][2];
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++)
        h[m][c] = (mq[m][c].size() > 0) ? mq[m][c][0] : 64'h0;
    bus.i_m0_rss_vld = (mq[0][0].size() > 0);
    bus.i_m0_rss     = h[0][0][8:0];
    bus.i_m0_rsd_vld = (mq[0][1].size() > 0);
    bus.i_m0_rsd     = h[0][1];
    bus.i_m1_rss_vld = (mq[1][0].size() > 0);
    bus.i_m1_rss     = h[1][0][8:0];
    bus.i_m1_rsd_vld = (mq[1][1].size() > 0);
    bus.i_m1_rsd     = h[1][1];
  endtask

  task automatic flush();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++) begin
        mq[m][c].delete();
        eq[m][c].delete();
        pop_f[m][c] = 1'b0;
      end
  endtask

  task automatic cycle(input bit s, input bit r0, input bit r1);
    logic [63:0] w;
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++)
        if (pop_f[m][c] && mq[m][c].size() > 0)
          void'(mq[m][c].pop_front());
    bus.i_m_sel   = s;
    bus.i_rss_rdy = r0;
    bus.i_rsd_rdy = r1;
    if (gen_on)
      for (int c = 0; c < 2; c++)
        if (mq[s][c].size() < 4 && $urandom_range(0, 3) != 0) begin
          w = mkword(int'(s), c, cnt[s][c]);
          cnt[s][c]++;
          mq[s][c].push_back(w);
          eq[s][c].push_back(w);
        end
    drive();
  endtask

  // Monitor / scoreboard
  logic        m_wr [2];
  logic        m_rdy [2];
  logic [63:0] m_w [2];
  logic        m_rd [2][2];
  logic        m_v [2][2];
  logic [63:0] m_h [2][2];
  bit          pv_pop [2];
  bit          pv_hold [2];
  logic [63:0] pv_head [2];
  logic [63:0] pv_w [2];

  always @(negedge clk) begin
    int          s;
    int          src;
    logic [63:0] e;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        pv_pop[c]  = 1'b0;
        pv_hold[c] = 1'b0;
        for (int m = 0; m < 2; m++) pop_f[m][c] = 1'b0;
      end
    end else begin
      s          = int'(bus.i_m_sel);
      m_wr[0]    = bus.o_rss_wr;
      m_rdy[0]   = bus.i_rss_rdy;
      m_w[0]     = 64'(bus.o_rss);
      m_wr[1]    = bus.o_rsd_wr;
      m_rdy[1]   = bus.i_rsd_rdy;
      m_w[1]     = bus.o_rsd;
      m_rd[0][0] = bus.o_m0_rss_rd;
      m_rd[1][0] = bus.o_m1_rss_rd;
      m_rd[0][1] = bus.o_m0_rsd_rd;
      m_rd[1][1] = bus.o_m1_rsd_rd;
      m_v[0][0]  = bus.i_m0_rss_vld;
      m_v[1][0]  = bus.i_m1_rss_vld;
      m_v[0][1]  = bus.i_m0_rsd_vld;
      m_v[1][1]  = bus.i_m1_rsd_vld;
      m_h[0][0]  = 64'(bus.i_m0_rss);
      m_h[1][0]  = 64'(bus.i_m1_rss);
      m_h[0][1]  = bus.i_m0_rsd;
      m_h[1][1]  = bus.i_m1_rsd;
      for (int c = 0; c < 2; c++) begin
        check("unsel_rd", 64'(m_rd[1-s][c]), 64'h0);
        if (BYP) begin
          check("sel_rd", 64'(m_rd[s][c]),
                64'(m_v[s][c] & m_rdy[c]));
          check("byp_wr", 64'(m_wr[c]), 64'(m_v[s][c]));
          if (m_wr[c]) check("byp_word", m_w[c], m_h[s][c]);
        end else begin
          check("sel_rd", 64'(m_rd[s][c]),
                64'(m_v[s][c] & (~m_wr[c] | m_rdy[c])));
          check("wr", 64'(m_wr[c]), 64'(pv_pop[c] | pv_hold[c]));
          if (pv_pop[c])
            check("load_word", m_w[c], pv_head[c]);
          else if (pv_hold[c])
            check("hold_word", m_w[c], pv_w[c]);
        end
        if (m_wr[c] && m_rdy[c]) begin
          if (c == 0) src = int'(m_w[c][8]);
          else        src = (m_w[c][63:56] == 8'hFE) ? 1 : 0;
          if (eq[src][c].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_extra: ch%0d got %h expected none",
                     c, m_w[c]);
          end else begin
            e = eq[src][c].pop_front();
            check("sb_order", m_w[c], e);
          end
        end
        for (int m = 0; m < 2; m++)
          pop_f[m][c] = m_rd[m][c] & m_v[m][c];
        pv_pop[c]  = m_rd[s][c] & m_v[s][c];
        pv_head[c] = m_h[s][c];
        pv_hold[c] = m_wr[c] & ~m_rdy[c];
        pv_w[c]    = m_w[c];
      end
    end
  end

  task automatic check_empty(input string name);
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++)
        check(name, 64'(eq[m][c].size()), 64'h0);
  endtask

  initial begin
    bit s;
    tests  = 0;
    fails  = 0;
    gen_on = 1'b0;
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++) cnt[m][c] = 0;
    flush();
    rst           = 1'b1;
    bus.i_m_sel   = 1'b0;
    bus.i_rss_rdy = 1'b0;
    bus.i_rsd_rdy = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rss", 64'(bus.o_rss), 64'h0);
    check("rst_rsd", bus.o_rsd, 64'h0);
    check("rst_rss_wr", 64'(bus.o_rss_wr), 64'h0);
    check("rst_rsd_wr", 64'(bus.o_rsd_wr), 64'h0);
    bus.i_m0_rss_vld = 1'b1;
    bus.i_rss_rdy    = 1'b1;
    #1;
    check("rst_rd", 64'(bus.o_m0_rss_rd), 64'h0);
    bus.i_rss_rdy = 1'b0;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Client stalled: output holds first word, master stops popping
    gen_on = 1'b1;
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("stall_rss", 64'(bus.o_rss), 64'h0);
    check("stall_wr", 64'(bus.o_rss_wr), 64'h1);
    check("stall_rd", 64'(bus.o_m0_rss_rd), 64'h0);
    check("stall_m1rd", 64'(bus.o_m1_rss_rd), 64'h0);
    check("stall_fill", 64'(mq[0][0].size()), 64'h4);

    // Full-rate drain then random back-pressure on master 0
    repeat (60) cycle(1'b0, 1'b1, 1'b1);
    repeat (150)
      cycle(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);

    gen_on = 1'b0;
    repeat (20) cycle(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("drain_rss_wr", 64'(bus.o_rss_wr), 64'h0);
    check("drain_rsd_wr", 64'(bus.o_rsd_wr), 64'h0);
    check_empty("drain_empty");

    // Master 1 stream with random select changes
    gen_on = 1'b1;
    repeat (100) cycle(1'b1, $urandom_range(0, 3) != 0, 1'b1);
    s = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) s = ~s;
      cycle(s, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end

    // Data stalled, status flowing, then reset mid-stream
    repeat (30) cycle(s, 1'b1, 1'b0);
    rst = 1'b1;
    flush();
    drive();
    @(posedge clk);
    #1;
    check("midrst_rss_wr", 64'(bus.o_rss_wr), 64'h0);
    check("midrst_rsd_wr", 64'(bus.o_rsd_wr), 64'h0);
    flush();
    drive();
    rst = 1'b0;

    // Fresh traffic after reset, then drain both masters
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) s = ~s;
      cycle(s, $urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0);
    end
    gen_on = 1'b0;
    repeat (20) cycle(1'b0, 1'b1, 1'b1);
    repeat (20) cycle(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check_empty("final_empty");

`ifdef VXE_CU_DS_BYPASS_EN
    @(posedge clk);
    #1;
    mq[0][0].push_back(64'h055);
    eq[0][0].push_back(64'h055);
    bus.i_m_sel   = 1'b0;
    bus.i_rss_rdy = 1'b1;
    drive();
    #1;
    check("byp_rss", 64'(bus.o_rss), 64'h055);
    check("byp_rss_wr", 64'(bus.o_rss_wr), 64'h1);
    check("byp_m0_rd", 64'(bus.o_m0_rss_rd), 64'h1);
    repeat (4) cycle(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_empty("byp_empty");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
